// File: rtl/ex_mul_seq_if.sv
// ex_mul_seq_if: bundles the ID/EX side, the EX ALU side and the status signals
// of the multiply sequencer.
`default_nettype none

interface ex_mul_seq_if;
  // ID/EX side
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [2:0]  pipe_func;
  logic [15:0] pipe_src0;
  logic [15:0] pipe_src1;
  logic        pipe_flag_en;
  // EX ALU side
  logic [15:0] alu_dst;
  logic [2:0]  alu_func;
  logic [15:0] alu_src0;
  logic [15:0] alu_src1;
  logic        flag_en;
  // status
  logic        stall;
  logic        busy;
  logic        done;
  logic [15:0] result;

  modport master (
    output start, op_a, op_b, pipe_func, pipe_src0, pipe_src1, pipe_flag_en, alu_dst,
    input  alu_func, alu_src0, alu_src1, flag_en, stall, busy, done, result
  );

  modport slave (
    input  start, op_a, op_b, pipe_func, pipe_src0, pipe_src1, pipe_flag_en, alu_dst,
    output alu_func, alu_src0, alu_src1, flag_en, stall, busy, done, result
  );
endinterface

`default_nettype wire

// File: rtl/ex_mul_seq.sv
// +----------------------------------------------------------------------------+
// | ex_mul_seq: shift-and-add 16x16 multiply (low 16 bits) on the shared EX ALU |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ex_mul_seq #(
  parameter logic [2:0] FUNC_ADD = 3'b000
) (
  input  logic         clk,
  input  logic         rst,
  ex_mul_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] acc;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [15:0] result_q;
  logic [3:0]  cnt;

  logic        accept;
  logic        last_step;

  assign accept    = bus.start && (state != RUN);
  // Stop once no multiplier bits remain above the one consumed this cycle.
  assign last_step = (mplier[15:1] == 15'd0) || (cnt == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.alu_func = bus.pipe_func;
    bus.alu_src0 = bus.pipe_src0;
    bus.alu_src1 = bus.pipe_src1;
    bus.flag_en  = bus.pipe_flag_en;
    bus.stall    = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (bus.op_b == 16'h0000) ? DONE : RUN;
        end
      end
      RUN: begin
        bus.alu_func = FUNC_ADD;
        bus.alu_src0 = acc;
        bus.alu_src1 = mplier[0] ? mcand : 16'h0000;
        bus.flag_en  = 1'b0;
        bus.stall    = 1'b1;
        bus.busy     = 1'b1;
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        if (accept) begin
          state_nxt = (bus.op_b == 16'h0000) ? DONE : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= 16'h0000;
      mcand    <= 16'h0000;
      mplier   <= 16'h0000;
      cnt      <= 4'd0;
      result_q <= 16'h0000;
    end else if (accept) begin
      acc    <= 16'h0000;
      mcand  <= bus.op_a;
      mplier <= bus.op_b;
      cnt    <= 4'd0;
      // A zero multiplier completes immediately, so its result lands now.
      if (bus.op_b == 16'h0000) begin
        result_q <= 16'h0000;
      end
    end else if (state == RUN) begin
      acc    <= bus.alu_dst;
      mcand  <= {mcand[14:0], 1'b0};
      mplier <= {1'b0, mplier[15:1]};
      cnt    <= cnt + 4'd1;
      if (last_step) begin
        result_q <= bus.alu_dst;
      end
    end
  end

  assign bus.result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_mul_seq.sv
// tb_ex_mul_seq: directed vectors against hand-computed products and timings.
`default_nettype none

module tb_ex_mul_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cyc;
  int   stalls;
  int   seen_done;

  ex_mul_seq_if bus ();

  ex_mul_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Simple EX ALU stand-in: ADD for func 000, XOR otherwise.
  assign bus.alu_dst = (bus.alu_func == 3'b000) ? (bus.alu_src0 + bus.alu_src1)
                                                : (bus.alu_src0 ^ bus.alu_src1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; afterwards the bench sits in cycle 1.
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // From cycle c, wait for done with a bound; returns the done cycle (or -1).
  task automatic wait_done(input int c, output int done_cyc);
    done_cyc = -1;
    for (int i = c; i < 60; i++) begin
      if (bus.done === 1'b1) begin
        done_cyc = i;
        break;
      end
      tick();
    end
    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.start = 1'b0;
    bus.op_a = 16'h0000;
    bus.op_b = 16'h0000;
    bus.pipe_func = 3'b000;
    bus.pipe_src0 = 16'h0000;
    bus.pipe_src1 = 16'h0000;
    bus.pipe_flag_en = 1'b0;
    tick();
    tick();
    check("rst_stall",  {31'd0, bus.stall}, 32'd0);
    check("rst_busy",   {31'd0, bus.busy},  32'd0);
    check("rst_done",   {31'd0, bus.done},  32'd0);
    check("rst_result", {16'd0, bus.result}, 32'd0);

    // start coincident with rst is dropped
    bus.op_a = 16'd3; bus.op_b = 16'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; rst = 1'b0;
    check("rst_wins_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    check("rst_wins_busy2", {31'd0, bus.busy}, 32'd0);

    // Pass-through in IDLE
    bus.pipe_func = 3'b011; bus.pipe_src0 = 16'hAAAA;
    bus.pipe_src1 = 16'h5555; bus.pipe_flag_en = 1'b1;
    #1;
    check("pt_func", {29'd0, bus.alu_func}, 32'h3);
    check("pt_src0", {16'd0, bus.alu_src0}, 32'hAAAA);
    check("pt_src1", {16'd0, bus.alu_src1}, 32'h5555);
    check("pt_flag", {31'd0, bus.flag_en},  32'h1);

    // 3 x 5 with cycle-exact ALU sequence
    launch(16'd3, 16'd5);
    check("c1_stall", {31'd0, bus.stall}, 32'd1);
    check("c1_src1",  {16'd0, bus.alu_src1}, 32'd3);
    check("c1_flag",  {31'd0, bus.flag_en}, 32'd0);
    check("c1_func",  {29'd0, bus.alu_func}, 32'd0);
    check("c1_busy",  {31'd0, bus.busy}, 32'd1);
    tick();
    check("c2_src1",  {16'd0, bus.alu_src1}, 32'd0);
    check("c2_src0",  {16'd0, bus.alu_src0}, 32'd3);
    tick();
    check("c3_src1",  {16'd0, bus.alu_src1}, 32'd12);
    check("c3_stall", {31'd0, bus.stall}, 32'd1);
    tick();
    check("c4_done",   {31'd0, bus.done}, 32'd1);
    check("c4_stall",  {31'd0, bus.stall}, 32'd0);
    check("c4_result", {16'd0, bus.result}, 32'h000F);
    check("c4_pt_src0", {16'd0, bus.alu_src0}, 32'hAAAA);
    tick();
    check("c5_done",   {31'd0, bus.done}, 32'd0);
    check("c5_result", {16'd0, bus.result}, 32'h000F);

    // 0x1234 x 0
    launch(16'h1234, 16'h0000);
    check("z_done",   {31'd0, bus.done}, 32'd1);
    check("z_stall",  {31'd0, bus.stall}, 32'd0);
    check("z_result", {16'd0, bus.result}, 32'd0);
    tick();

    // 0xFFFF x 0xFFFF: 16 RUN cycles
    launch(16'hFFFF, 16'hFFFF);
    cyc = 1; stalls = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (bus.stall === 1'b1) stalls++;
      tick();
      cyc++;
    end
    check("ff_done_cyc", cyc, 32'd17);
    check("ff_stalls",   stalls, 32'd16);
    check("ff_result",   {16'd0, bus.result}, 32'h0001);
    tick();

    // Reset mid-RUN
    launch(16'd7, 16'h8000);
    tick(); tick(); tick(); tick();
    check("mr_c5_stall", {31'd0, bus.stall}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_stall",  {31'd0, bus.stall}, 32'd0);
    check("mr_busy",   {31'd0, bus.busy}, 32'd0);
    check("mr_result", {16'd0, bus.result}, 32'd0);
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
      tick();
    end
    check("mr_no_done", seen_done, 32'd0);
    launch(16'd2, 16'd2);
    wait_done(1, cyc);
    check("mr_2x2_cyc", cyc, 32'd3);
    check("mr_2x2",     {16'd0, bus.result}, 32'd4);
    tick();

    // Start during RUN is ignored; operand changes have no effect
    launch(16'd3, 16'h8001);
    tick();
    bus.op_a = 16'd5; bus.op_b = 16'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.op_a = 16'h1111; bus.pipe_func = 3'b101;
    wait_done(3, cyc);
    check("sr_done_cyc", cyc, 32'd17);
    check("sr_result",   {16'd0, bus.result}, 32'h8003);

    // Start in DONE: old result shown, new one lands at its own completion
    bus.op_a = 16'd2; bus.op_b = 16'd3; bus.start = 1'b1;
    #1;
    check("sd_done_old", {31'd0, bus.done}, 32'd1);
    check("sd_res_old",  {16'd0, bus.result}, 32'h8003);
    tick();
    bus.start = 1'b0;
    check("sd_busy",     {31'd0, bus.busy}, 32'd1);
    check("sd_res_hold", {16'd0, bus.result}, 32'h8003);
    wait_done(1, cyc);
    check("sd_done_cyc", cyc, 32'd3);
    check("sd_result",   {16'd0, bus.result}, 32'd6);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_mul_seq.md
# ex_mul_seq

Multi-cycle multiply sequencer for the execute stage. It borrows the shared EX ALU to compute a 16x16 multiply (low 16 product bits) by shift-and-add. It stalls the pipeline while it owns the ALU and passes the pipeline's ALU controls straight through otherwise. It sits between ID/EX control and the EX ALU inputs, and issues one ALU ADD per multiplier bit.

## Interface
- FUNC_ADD, 3'b000, ALU func encoding driven during accumulate cycles
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: MUL decoded, op_a/op_b valid
- op_a  in  16  multiplicand
- op_b  in  16  multiplier
- pipe_func  in  3  pipeline ALU func (pass-through)
- pipe_src0  in  16  pipeline ALU src0 (pass-through)
- pipe_src1  in  16  pipeline ALU src1 (pass-through)
- pipe_flag_en  in  1  pipeline N/Z/V write enable (pass-through)
- alu_dst  in  16  ALU result
- alu_func  out  3  to ALU ops
- alu_src0  out  16  to ALU src0
- alu_src1  out  16  to ALU src1
- flag_en  out  1  N/Z/V write enable to flag register
- stall  out  1  freeze PC/IF/ID while high
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse, result valid
- result  out  16  product low 16 bits; holds until next accepted start

## Operation
- States: IDLE, RUN, DONE. Reset: state=IDLE; acc, mcand, mplier, cnt[3:0], result = 0; stall=busy=done=0.
- IDLE and DONE:
  - alu_func/src0/src1/flag_en = pipe_func/pipe_src0/pipe_src1/pipe_flag_en, combinationally.
  - stall=0.
- start is accepted in IDLE or DONE; ignored in RUN.
- On an accepted start, load mcand=op_a, mplier=op_b, acc=0, cnt=0.
  - If op_b==0, go to DONE with result=0.
  - Otherwise go to RUN.
- RUN, each cycle:
  - Drive alu_func=FUNC_ADD, alu_src0=acc, alu_src1 = mplier[0] ? mcand : 16'h0000.
  - Drive flag_en=0, stall=1, busy=1.
  - On the edge: acc<=alu_dst, mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
- Exit RUN on the edge where (mplier>>1)==0 or cnt==15. Then result<=alu_dst and go to DONE.
- DONE lasts one cycle with done=1, then goes to IDLE unless a new start is accepted.
- Arithmetic is modulo 2^16: overflow is discarded, and the low 16 bits are identical for signed and unsigned operands.
- Flags are never written by multiply accumulate cycles. A MUL leaves N/Z/V unchanged.

## Timing
- Start sampled at edge 0. Let k = position of the highest set bit of op_b, plus 1 (range 1..16).
  - RUN occupies cycles 1..k.
  - DONE (done=1, result valid) occurs at cycle k+1.
  - Stall spans cycles 1..k.
- op_b==0: DONE at cycle 1, no RUN cycles, stall never asserted.
- Maximum latency: 17 cycles (op_b[15]=1).
- rst asserted in any state returns the block to IDLE on the next edge.
  - An in-flight multiply is abandoned: no done pulse, result=0.
  - stall drops after that edge.
- Start coincident with rst: rst wins.
- Start in DONE: done is still 1 that cycle with the old result. The new operation then proceeds as from IDLE, and result is overwritten only at the new completion.
- op_a/op_b/pipe_* changes during RUN have no effect.

## Test plan
- 3 x 5:
  - op_a=3, op_b=5, start at cycle 0.
  - Required: stall=1 for cycles 1-3, alu_src1 sequence 3,0,12, done at cycle 4, result=0x000F, flag_en=0 during RUN.
- 0x1234 x 0: done at cycle 1, result=0, stall never high.
- 0xFFFF x 0xFFFF: 16 RUN cycles, done at cycle 17, result=0x0001.
- Reset mid-RUN:
  - 7 x 0x8000, rst high at cycle 5.
  - Required: state IDLE at cycle 6, stall=0, no done pulse, result=0.
  - A following 2 x 2 gives result=4.
- Start during RUN:
  - Second start with op_b=1 at cycle 2 of a 16-cycle multiply.
  - Required: it is ignored, and the original product is correct.
- Pass-through:
  - In IDLE, pipe_func=3'b011, pipe_src0=0xAAAA, pipe_src1=0x5555, pipe_flag_en=1.
  - Required: identical values on the alu_* outputs and flag_en in the same cycle.
